// File: rtl/jtag_mailbox_ctrl.sv
// Host-register mailbox: debounces host commands by tag, forwards READ/WRITE requests to a target.
// Optional request timeout is enabled by defining JTAG_MBOX_TIMEOUT_EN.
module jtag_mailbox_ctrl #(
    parameter int unsigned WIDTH          = 32,
    parameter int unsigned NUM_TARGETS    = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic             iMAIN_CLK,
    input  logic             iRESET_N,
    input  logic [WIDTH-1:0] iHOST_CMD,
    input  logic [WIDTH-1:0] iHOST_WDATA,
    output logic [WIDTH-1:0] oHOST_STATUS,
    output logic [WIDTH-1:0] oHOST_RDATA,
    output logic             oREQ_VALID,
    output logic             oREQ_WE,
    output logic [3:0]       oREQ_TARGET,
    output logic [WIDTH-1:0] oREQ_WDATA,
    input  logic             iREQ_ACK,
    input  logic [WIDTH-1:0] iREQ_RDATA
);

    if (WIDTH < 32 || NUM_TARGETS < 1 || NUM_TARGETS > 16 || TIMEOUT_CYCLES < 1) begin : g_bad_param
        $error("jtag_mailbox_ctrl: parameter out of range");
    end

    localparam logic [1:0] OpNop   = 2'b00;
    localparam logic [1:0] OpWrite = 2'b01;
    localparam logic [1:0] OpRead  = 2'b10;

    localparam logic [1:0] CodeOk        = 2'b00;
    localparam logic [1:0] CodeBadTarget = 2'b01;
    localparam logic [1:0] CodeTimeout   = 2'b10;
    localparam logic [1:0] CodeBadOp     = 2'b11;

    typedef enum logic [1:0] {StIdle, StQualify, StIssue, StDone} state_e;

    state_e           state_q, state_d;
    logic [7:0]       last_tag_q, last_tag_d;
    logic [WIDTH-1:0] cap_cmd_q, cap_cmd_d;
    logic [WIDTH-1:0] cap_wdata_q, cap_wdata_d;
    logic [7:0]       st_tag_q, st_tag_d;
    logic             st_busy_q, st_busy_d;
    logic [1:0]       st_code_q, st_code_d;
    logic [WIDTH-1:0] rdata_q, rdata_d;
    logic             req_valid_q, req_valid_d;
    logic             req_we_q, req_we_d;
    logic [3:0]       req_target_q, req_target_d;
    logic [WIDTH-1:0] req_wdata_q, req_wdata_d;

    logic       new_tag, cmd_stable, bad_target, is_rw, issue_ok, ack_hit, expire;
    logic [1:0] cap_op;
    logic [3:0] cap_target;

    assign cap_op     = cap_cmd_q[9:8];
    assign cap_target = cap_cmd_q[15:12];
    assign new_tag    = (iHOST_CMD[7:0] != last_tag_q);
    assign cmd_stable = (iHOST_CMD == cap_cmd_q) && (iHOST_WDATA == cap_wdata_q);
    assign bad_target = (32'(cap_target) >= NUM_TARGETS);
    assign is_rw      = (cap_op == OpWrite) || (cap_op == OpRead);
    assign issue_ok   = is_rw && !bad_target;
    assign ack_hit    = req_valid_q && iREQ_ACK;

`ifdef JTAG_MBOX_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    // Counts cycles spent in ISSUE; the expiry cycle is the TIMEOUT_CYCLES-th one.
    always_comb cnt_d = (state_q == StIssue) ? cnt_q + 1'b1 : '0;

    always_ff @(posedge iMAIN_CLK or negedge iRESET_N) begin
        if (!iRESET_N) cnt_q <= '0;
        else           cnt_q <= cnt_d;
    end

    assign expire = (cnt_q == CntW'(TIMEOUT_CYCLES - 1));
`else
    assign expire = 1'b0;
`endif

    always_ff @(posedge iMAIN_CLK or negedge iRESET_N) begin
        if (!iRESET_N) state_q <= StIdle;
        else           state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:    if (new_tag) state_d = StQualify;
            StQualify: begin
                if (cmd_stable)    state_d = issue_ok ? StIssue : StDone;
                else if (!new_tag) state_d = StIdle;
            end
            StIssue:   if (ack_hit || expire) state_d = StDone;
            StDone:    state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    always_comb begin
        last_tag_d   = last_tag_q;
        cap_cmd_d    = cap_cmd_q;
        cap_wdata_d  = cap_wdata_q;
        st_tag_d     = st_tag_q;
        st_busy_d    = st_busy_q;
        st_code_d    = st_code_q;
        rdata_d      = rdata_q;
        req_valid_d  = req_valid_q;
        req_we_d     = req_we_q;
        req_target_d = req_target_q;
        req_wdata_d  = req_wdata_q;
        unique case (state_q)
            StIdle: begin
                if (new_tag) begin
                    cap_cmd_d   = iHOST_CMD;
                    cap_wdata_d = iHOST_WDATA;
                end
            end
            StQualify: begin
                if (cmd_stable) begin
                    last_tag_d = cap_cmd_q[7:0];
                    st_tag_d   = cap_cmd_q[7:0];
                    if (issue_ok) begin
                        st_busy_d    = 1'b1;
                        st_code_d    = CodeOk;
                        req_valid_d  = 1'b1;
                        req_we_d     = (cap_op == OpWrite);
                        req_target_d = cap_target;
                        req_wdata_d  = cap_wdata_q;
                    end else begin
                        st_busy_d = 1'b0;
                        if (cap_op == OpNop)   st_code_d = CodeOk;
                        else if (!is_rw)       st_code_d = CodeBadOp;
                        else                   st_code_d = CodeBadTarget;
                    end
                end else begin
                    cap_cmd_d   = iHOST_CMD;
                    cap_wdata_d = iHOST_WDATA;
                end
            end
            StIssue: begin
                // An ack in the expiry cycle takes priority over the timeout.
                if (ack_hit) begin
                    req_valid_d = 1'b0;
                    st_busy_d   = 1'b0;
                    st_code_d   = CodeOk;
                    if (!req_we_q) rdata_d = iREQ_RDATA;
                end else if (expire) begin
                    req_valid_d = 1'b0;
                    st_busy_d   = 1'b0;
                    st_code_d   = CodeTimeout;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge iMAIN_CLK or negedge iRESET_N) begin
        if (!iRESET_N) begin
            last_tag_q   <= '0;
            cap_cmd_q    <= '0;
            cap_wdata_q  <= '0;
            st_tag_q     <= '0;
            st_busy_q    <= 1'b0;
            st_code_q    <= CodeOk;
            rdata_q      <= '0;
            req_valid_q  <= 1'b0;
            req_we_q     <= 1'b0;
            req_target_q <= '0;
            req_wdata_q  <= '0;
        end else begin
            last_tag_q   <= last_tag_d;
            cap_cmd_q    <= cap_cmd_d;
            cap_wdata_q  <= cap_wdata_d;
            st_tag_q     <= st_tag_d;
            st_busy_q    <= st_busy_d;
            st_code_q    <= st_code_d;
            rdata_q      <= rdata_d;
            req_valid_q  <= req_valid_d;
            req_we_q     <= req_we_d;
            req_target_q <= req_target_d;
            req_wdata_q  <= req_wdata_d;
        end
    end

    assign oHOST_STATUS = {{(WIDTH - 11){1'b0}}, st_code_q, st_busy_q, st_tag_q};
    assign oHOST_RDATA  = rdata_q;
    assign oREQ_VALID   = req_valid_q;
    assign oREQ_WE      = req_we_q;
    assign oREQ_TARGET  = req_target_q;
    assign oREQ_WDATA   = req_wdata_q;

endmodule

// File: tb/tb_jtag_mailbox_ctrl.sv
// Scenario-driven bench for jtag_mailbox_ctrl; expected completions are queued at drive time
// and popped when the DUT finishes each command.
module tb_jtag_mailbox_ctrl;

    localparam int unsigned W = 32;

    localparam logic [1:0] OP_NOP = 2'b00, OP_WR = 2'b01, OP_RD = 2'b10, OP_RSV = 2'b11;
    localparam logic [1:0] C_OK = 2'b00, C_BADT = 2'b01, C_TMO = 2'b10, C_BADOP = 2'b11;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic [W-1:0] cmd = '0;
    logic [W-1:0] wdata = '0;
    logic         ack = 1'b0;
    logic [W-1:0] ack_rdata = '0;
    logic [W-1:0] host_status, host_rdata, req_wdata;
    logic         req_valid, req_we;
    logic [3:0]   req_target;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic [7:0]   tag;
        logic [1:0]   code;
        logic         we;
        logic [3:0]   tgt;
        logic [W-1:0] wd;
        logic [W-1:0] rdata;
    } exp_t;

    exp_t sb_q[$];

    jtag_mailbox_ctrl #(
        .WIDTH(W),
        .NUM_TARGETS(4),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .iMAIN_CLK(clk),
        .iRESET_N(rst_n),
        .iHOST_CMD(cmd),
        .iHOST_WDATA(wdata),
        .oHOST_STATUS(host_status),
        .oHOST_RDATA(host_rdata),
        .oREQ_VALID(req_valid),
        .oREQ_WE(req_we),
        .oREQ_TARGET(req_target),
        .oREQ_WDATA(req_wdata),
        .iREQ_ACK(ack),
        .iREQ_RDATA(ack_rdata)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [W-1:0] mk_cmd(input logic [7:0] tag, input logic [1:0] op,
                                            input logic [3:0] tgt);
        return {16'h0, tgt, 2'b00, op, tag};
    endfunction

    function automatic exp_t mk_exp(input logic [7:0] tag, input logic [1:0] code, input logic we,
                                    input logic [3:0] tgt, input logic [W-1:0] wd,
                                    input logic [W-1:0] rdata);
        exp_t e;
        e.tag = tag; e.code = code; e.we = we; e.tgt = tgt; e.wd = wd; e.rdata = rdata;
        return e;
    endfunction

    task automatic wait_valid(input int max, output int n);
        n = 0;
        while (!req_valid && n < max) begin
            tick();
            n++;
        end
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        cmd = '0; wdata = '0; ack = 1'b0;
        #2;
        n_checks++;
        if ({req_valid, req_we, req_target, req_wdata, host_status, host_rdata} !== '0)
            $display("FAIL reset_outputs: got v=%b we=%b t=%h wd=%h st=%h rd=%h want all zero",
                     req_valid, req_we, req_target, req_wdata, host_status, host_rdata);
        else n_pass++;
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (4) tick();
        n_checks++;
        if ({req_valid, host_status} !== '0)
            $display("FAIL tag0_after_reset: got v=%b st=%h want v=0 st=0", req_valid, host_status);
        else n_pass++;
    endtask

    task automatic test_write();
        exp_t e;
        sb_q.push_back(mk_exp(8'h01, C_OK, 1'b1, 4'd2, 32'hDEADBEEF, 32'h0));
        cmd = mk_cmd(8'h01, OP_WR, 4'd2);
        wdata = 32'hDEADBEEF;
        tick();
        n_checks++;
        if (req_valid !== 1'b0) $display("FAIL write_n1_valid: got %b want 0", req_valid);
        else n_pass++;
        tick();
        e = sb_q[0];
        n_checks++;
        if ({req_valid, req_we, req_target, req_wdata, host_status[8:0]} !==
            {1'b1, e.we, e.tgt, e.wd, 1'b1, e.tag})
            $display("FAIL write_req: got v=%b we=%b t=%h wd=%h st=%h want v=1 we=%b t=%h wd=%h tag=%h busy=1",
                     req_valid, req_we, req_target, req_wdata, host_status, e.we, e.tgt, e.wd, e.tag);
        else n_pass++;
        repeat (2) begin
            tick();
            n_checks++;
            if ({req_valid, req_we, req_target, req_wdata} !== {1'b1, e.we, e.tgt, e.wd})
                $display("FAIL write_hold: got v=%b we=%b t=%h wd=%h want held request",
                         req_valid, req_we, req_target, req_wdata);
            else n_pass++;
        end
        ack = 1'b1;
        tick();
        ack = 1'b0;
        e = sb_q.pop_front();
        n_checks++;
        if ({req_valid, host_status, host_rdata} !== {1'b0, 21'h0, e.code, 1'b0, e.tag, e.rdata})
            $display("FAIL write_done: got v=%b st=%h rd=%h want v=0 tag=%h code=%0d rd=%h",
                     req_valid, host_status, host_rdata, e.tag, e.code, e.rdata);
        else n_pass++;
        tick();
        ack = 1'b1;
        ack_rdata = 32'hFFFF_FFFF;
        repeat (2) tick();
        ack = 1'b0;
        n_checks++;
        if ({req_valid, host_status, host_rdata} !== {1'b0, 21'h0, C_OK, 1'b0, 8'h01, 32'h0})
            $display("FAIL stray_ack: got v=%b st=%h rd=%h want v=0 st=00000001 rd=0",
                     req_valid, host_status, host_rdata);
        else n_pass++;
    endtask

    task automatic test_read();
        exp_t e;
        int   n;
        sb_q.push_back(mk_exp(8'h02, C_OK, 1'b0, 4'd1, 32'h0, 32'h12345678));
        cmd = mk_cmd(8'h02, OP_RD, 4'd1);
        wdata = '0;
        ack_rdata = 32'h12345678;
        wait_valid(6, n);
        e = sb_q[0];
        n_checks++;
        if ({req_valid, req_we, req_target, n} !== {1'b1, e.we, e.tgt, 32'd2})
            $display("FAIL read_req: got v=%b we=%b t=%h after %0d cycles want v=1 we=0 t=1 after 2",
                     req_valid, req_we, req_target, n);
        else n_pass++;
        tick();
        ack = 1'b1;
        tick();
        ack = 1'b0;
        e = sb_q.pop_front();
        n_checks++;
        if ({req_valid, host_status, host_rdata} !== {1'b0, 21'h0, e.code, 1'b0, e.tag, e.rdata})
            $display("FAIL read_done: got v=%b st=%h rd=%h want v=0 tag=%h code=%0d rd=%h",
                     req_valid, host_status, host_rdata, e.tag, e.code, e.rdata);
        else n_pass++;
        repeat (2) tick();
    endtask

    task automatic test_errors();
        exp_t e;
        logic [7:0]   tags [3] = '{8'h03, 8'h04, 8'h08};
        logic [1:0]   ops  [3] = '{OP_WR, OP_RSV, OP_NOP};
        logic [3:0]   tgts [3] = '{4'd7, 4'd0, 4'd9};
        logic [1:0]   codes[3] = '{C_BADT, C_BADOP, C_OK};
        for (int i = 0; i < 3; i++) begin
            sb_q.push_back(mk_exp(tags[i], codes[i], 1'b0, 4'd0, 32'h0, 32'h12345678));
            cmd = mk_cmd(tags[i], ops[i], tgts[i]);
            wdata = 32'h1111_0000 + i;
            tick();
            n_checks++;
            if (req_valid !== 1'b0) $display("FAIL err_n1_valid[%0d]: got %b want 0", i, req_valid);
            else n_pass++;
            tick();
            e = sb_q.pop_front();
            n_checks++;
            if ({req_valid, host_status, host_rdata} !== {1'b0, 21'h0, e.code, 1'b0, e.tag, e.rdata})
                $display("FAIL err_status[%0d]: got v=%b st=%h rd=%h want v=0 tag=%h code=%0d rd=%h",
                         i, req_valid, host_status, host_rdata, e.tag, e.code, e.rdata);
            else n_pass++;
            repeat (2) tick();
            if (i == 1) begin
                cmd = mk_cmd(8'h04, OP_WR, 4'd1);
                wdata = 32'h2222_2222;
                repeat (5) begin
                    tick();
                    n_checks++;
                    if ({req_valid, host_status} !== {1'b0, 21'h0, C_BADOP, 1'b0, 8'h04})
                        $display("FAIL tag_reuse: got v=%b st=%h want v=0 st=00000604",
                                 req_valid, host_status);
                    else n_pass++;
                end
            end
        end
    endtask

    task automatic test_glitch();
        exp_t e;
        int   n;
        cmd = mk_cmd(8'h05, OP_RD, 4'd0);
        wdata = '0;
        tick();
        sb_q.push_back(mk_exp(8'h06, C_OK, 1'b1, 4'd3, 32'hAAAA5555, 32'h12345678));
        cmd = mk_cmd(8'h06, OP_WR, 4'd3);
        wdata = 32'hAAAA5555;
        tick();
        n_checks++;
        if (req_valid !== 1'b0) $display("FAIL glitch_requalify: got v=%b want 0", req_valid);
        else n_pass++;
        tick();
        e = sb_q[0];
        n_checks++;
        if ({req_valid, req_we, req_target, req_wdata, host_status[8:0]} !==
            {1'b1, e.we, e.tgt, e.wd, 1'b1, e.tag})
            $display("FAIL glitch_req6: got v=%b we=%b t=%h wd=%h st=%h want tag 06 write t=3",
                     req_valid, req_we, req_target, req_wdata, host_status);
        else n_pass++;
        sb_q.push_back(mk_exp(8'h07, C_OK, 1'b1, 4'd0, 32'h77777777, 32'h12345678));
        cmd = mk_cmd(8'h07, OP_WR, 4'd0);
        wdata = 32'h77777777;
        repeat (3) begin
            tick();
            n_checks++;
            if ({req_valid, req_we, req_target, req_wdata, host_status[8:0]} !==
                {1'b1, e.we, e.tgt, e.wd, 1'b1, e.tag})
                $display("FAIL busy_ignore: got v=%b t=%h wd=%h st=%h want tag 06 request held",
                         req_valid, req_target, req_wdata, host_status);
            else n_pass++;
        end
        ack = 1'b1;
        tick();
        ack = 1'b0;
        e = sb_q.pop_front();
        n_checks++;
        if ({req_valid, host_status} !== {1'b0, 21'h0, e.code, 1'b0, e.tag})
            $display("FAIL glitch_done6: got v=%b st=%h want v=0 tag=%h OK", req_valid, host_status, e.tag);
        else n_pass++;
        wait_valid(8, n);
        e = sb_q[0];
        n_checks++;
        if ({req_valid, req_we, req_target, req_wdata, host_status[8:0]} !==
            {1'b1, e.we, e.tgt, e.wd, 1'b1, e.tag})
            $display("FAIL tag7_req: got v=%b t=%h wd=%h st=%h after %0d cycles want tag 07 write t=0",
                     req_valid, req_target, req_wdata, host_status, n);
        else n_pass++;
        ack = 1'b1;
        tick();
        ack = 1'b0;
        e = sb_q.pop_front();
        n_checks++;
        if ({req_valid, host_status, host_rdata} !== {1'b0, 21'h0, e.code, 1'b0, e.tag, e.rdata})
            $display("FAIL tag7_done: got v=%b st=%h rd=%h want v=0 tag=%h OK rd=%h",
                     req_valid, host_status, host_rdata, e.tag, e.rdata);
        else n_pass++;
        repeat (2) tick();
    endtask

    task automatic test_timeout();
        exp_t e;
        int   n;
        cmd = mk_cmd(8'h09, OP_RD, 4'd0);
        wdata = '0;
        ack_rdata = 32'hDEAD0000;
`ifdef JTAG_MBOX_TIMEOUT_EN
        sb_q.push_back(mk_exp(8'h09, C_TMO, 1'b0, 4'd0, 32'h0, 32'h12345678));
        wait_valid(6, n);
        repeat (15) begin
            tick();
            n_checks++;
            if (req_valid !== 1'b1) $display("FAIL timeout_hold: got v=%b want 1", req_valid);
            else n_pass++;
        end
        tick();
        e = sb_q.pop_front();
        n_checks++;
        if ({req_valid, host_status, host_rdata} !== {1'b0, 21'h0, e.code, 1'b0, e.tag, e.rdata})
            $display("FAIL timeout_expire: got v=%b st=%h rd=%h want v=0 tag=%h code=%0d rd=%h",
                     req_valid, host_status, host_rdata, e.tag, e.code, e.rdata);
        else n_pass++;
        repeat (2) tick();
        sb_q.push_back(mk_exp(8'h0A, C_OK, 1'b0, 4'd0, 32'h0, 32'hCAFEF00D));
        cmd = mk_cmd(8'h0A, OP_RD, 4'd0);
        ack_rdata = 32'hCAFEF00D;
        wait_valid(6, n);
        repeat (15) tick();
        n_checks++;
        if (req_valid !== 1'b1) $display("FAIL pre_expiry_valid: got v=%b want 1", req_valid);
        else n_pass++;
        ack = 1'b1;
        tick();
        ack = 1'b0;
        e = sb_q.pop_front();
        n_checks++;
        if ({req_valid, host_status, host_rdata} !== {1'b0, 21'h0, e.code, 1'b0, e.tag, e.rdata})
            $display("FAIL ack_at_expiry: got v=%b st=%h rd=%h want v=0 tag=%h OK rd=%h",
                     req_valid, host_status, host_rdata, e.tag, e.rdata);
        else n_pass++;
`else
        sb_q.push_back(mk_exp(8'h09, C_OK, 1'b0, 4'd0, 32'h0, 32'hDEAD0000));
        wait_valid(6, n);
        repeat (40) begin
            tick();
            n_checks++;
            if ({req_valid, host_status[10:8]} !== {1'b1, C_OK, 1'b1})
                $display("FAIL no_timeout: got v=%b st=%h want v=1 busy OK", req_valid, host_status);
            else n_pass++;
        end
        ack = 1'b1;
        tick();
        ack = 1'b0;
        e = sb_q.pop_front();
        n_checks++;
        if ({req_valid, host_status, host_rdata} !== {1'b0, 21'h0, e.code, 1'b0, e.tag, e.rdata})
            $display("FAIL late_ack_done: got v=%b st=%h rd=%h want v=0 tag=%h OK rd=%h",
                     req_valid, host_status, host_rdata, e.tag, e.rdata);
        else n_pass++;
`endif
        repeat (2) tick();
    endtask

    task automatic test_reset_mid_issue();
        exp_t e;
        int   n;
        sb_q.push_back(mk_exp(8'h0B, C_OK, 1'b1, 4'd1, 32'hBBBB_BBBB, 32'h0));
        cmd = mk_cmd(8'h0B, OP_WR, 4'd1);
        wdata = 32'hBBBB_BBBB;
        wait_valid(6, n);
        n_checks++;
        if (req_valid !== 1'b1) $display("FAIL mid_issue_valid: got v=%b want 1", req_valid);
        else n_pass++;
        #2 rst_n = 1'b0;
        #1;
        sb_q.delete();
        n_checks++;
        if ({req_valid, host_status, host_rdata} !== '0)
            $display("FAIL reset_abort: got v=%b st=%h rd=%h want all zero",
                     req_valid, host_status, host_rdata);
        else n_pass++;
        cmd = '0;
        wdata = '0;
        tick();
        rst_n = 1'b1;
        repeat (4) tick();
        n_checks++;
        if ({req_valid, host_status} !== '0)
            $display("FAIL tag0_ignored: got v=%b st=%h want v=0 st=0", req_valid, host_status);
        else n_pass++;
        sb_q.push_back(mk_exp(8'h01, C_OK, 1'b1, 4'd2, 32'h13572468, 32'h0));
        cmd = mk_cmd(8'h01, OP_WR, 4'd2);
        wdata = 32'h13572468;
        wait_valid(6, n);
        e = sb_q[0];
        n_checks++;
        if ({req_valid, req_we, req_target, req_wdata, n} !== {1'b1, e.we, e.tgt, e.wd, 32'd2})
            $display("FAIL post_reset_req: got v=%b we=%b t=%h wd=%h after %0d want v=1 t=2 after 2",
                     req_valid, req_we, req_target, req_wdata, n);
        else n_pass++;
        ack = 1'b1;
        tick();
        ack = 1'b0;
        e = sb_q.pop_front();
        n_checks++;
        if ({req_valid, host_status, host_rdata} !== {1'b0, 21'h0, e.code, 1'b0, e.tag, e.rdata})
            $display("FAIL post_reset_done: got v=%b st=%h rd=%h want v=0 tag=%h OK rd=%h",
                     req_valid, host_status, host_rdata, e.tag, e.rdata);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_errors();
        test_glitch();
        test_timeout();
        test_reset_mid_issue();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

endmodule
